// File: rtl/test_indicator_regs.sv
// test_indicator_regs
//   Bank of per-test status registers written by test software to report
//   pass/fail. A register locks once its status field goes nonzero so a later
//   stray write cannot overwrite a reported result. The first register to
//   lock with the fail code is captured in fail_valid/fail_idx.
//
// Ports
//   clock, reset       sole clock, synchronous active-high reset
//   req_*              single-beat request (valid/ready), byte address,
//                      write data and byte enables
//   rsp_*              response (valid/ready), read data, error flag
//   status_regs        register contents, straight from flops
//   fail_valid         some register locked with the fail code
//   fail_idx           index of the first such register
module test_indicator_regs #(
   parameter int unsigned NCONCURRENT = 1,
   parameter int unsigned CODEBITS    = 16,
   parameter int unsigned REGBYTES    = 4,
   parameter int unsigned ADDRBITS    = 12
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  req_valid,
   output logic                                  req_ready,
   input  logic                                  req_write,
   input  logic [ADDRBITS-1:0]                   req_addr,
   input  logic [8*REGBYTES-1:0]                 req_data,
   input  logic [REGBYTES-1:0]                   req_mask,
   output logic                                  rsp_valid,
   input  logic                                  rsp_ready,
   output logic [8*REGBYTES-1:0]                 rsp_data,
   output logic                                  rsp_error,
   output logic [NCONCURRENT-1:0][8*REGBYTES-1:0] status_regs,
   output logic                                  fail_valid,
   output logic [5:0]                            fail_idx
);

   localparam int unsigned RegW = 8 * REGBYTES;
   // Repeating 0011 pattern; 16'h3333 for a 16-bit status field.
   localparam logic [CODEBITS-1:0] FailCode = CODEBITS'({16{4'h3}});

   typedef enum logic {StIdle, StResp} state_e;

   state_e                  state_q, state_d;
   logic [NCONCURRENT-1:0]  lock_q;

   logic                    accept;
   logic [ADDRBITS-1:0]     reg_idx;
   logic                    addr_ok;
   logic [RegW-1:0]         cur_val;
   logic                    cur_lock;
   logic [RegW-1:0]         merged;
   logic                    wr_ok;
   logic [RegW-1:0]         rsp_data_d;
   logic                    rsp_error_d;

   assign req_ready = (state_q == StIdle) && !reset;
   assign rsp_valid = (state_q == StResp);
   assign accept    = req_valid && req_ready;

   assign reg_idx = req_addr / ADDRBITS'(REGBYTES);
   assign addr_ok = ((req_addr % ADDRBITS'(REGBYTES)) == '0) &&
                    (reg_idx < ADDRBITS'(NCONCURRENT));

   // Address decode and byte merge for the addressed register.
   always_comb begin
      cur_val  = '0;
      cur_lock = 1'b0;
      for (int i = 0; i < int'(NCONCURRENT); i++) begin
         if (ADDRBITS'(i) == reg_idx) begin
            cur_val  = status_regs[i];
            cur_lock = lock_q[i];
         end
      end
      merged = cur_val;
      for (int b = 0; b < int'(REGBYTES); b++) begin
         if (req_mask[b]) merged[8*b +: 8] = req_data[8*b +: 8];
      end
      wr_ok       = accept && req_write && addr_ok && !cur_lock;
      rsp_error_d = !addr_ok || (req_write && cur_lock);
      rsp_data_d  = (addr_ok && !req_write) ? cur_val : '0;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StResp;
         StResp:  if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         status_regs <= '0;
         lock_q      <= '0;
         rsp_data    <= '0;
         rsp_error   <= 1'b0;
         fail_valid  <= 1'b0;
         fail_idx    <= '0;
      end else begin
         state_q <= state_d;
         // Payload only changes on accept, so it holds under backpressure.
         if (accept) begin
            rsp_data  <= rsp_data_d;
            rsp_error <= rsp_error_d;
         end
         if (wr_ok) begin
            for (int i = 0; i < int'(NCONCURRENT); i++) begin
               if (ADDRBITS'(i) == reg_idx) begin
                  status_regs[i] <= merged;
                  if (merged[CODEBITS-1:0] != '0) lock_q[i] <= 1'b1;
               end
            end
            if ((merged[CODEBITS-1:0] == FailCode) && !fail_valid) begin
               fail_valid <= 1'b1;
               fail_idx   <= reg_idx[5:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_test_indicator_regs.sv
// Self-checking bench for test_indicator_regs (4 registers, 16-bit status).
// Directed scenarios followed by randomized requests checked against a
// behavioural register model.
module tb_test_indicator_regs;

   localparam int N = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [11:0]       req_addr;
   logic [31:0]       req_data;
   logic [3:0]        req_mask;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_data;
   logic              rsp_error;
   logic [N-1:0][31:0] status_regs;
   logic              fail_valid;
   logic [5:0]        fail_idx;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   logic [31:0] m_reg [N];
   bit          m_lock [N];
   bit          m_fv;
   int          m_fi;

   test_indicator_regs #(
      .NCONCURRENT (N),
      .CODEBITS    (16),
      .REGBYTES    (4),
      .ADDRBITS    (12)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_mask    (req_mask),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_error   (rsp_error),
      .status_regs (status_regs),
      .fail_valid  (fail_valid),
      .fail_idx    (fail_idx)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      logic [N-1:0][31:0] exp_sr;
      for (int i = 0; i < N; i++) exp_sr[i] = m_reg[i];
      chk({tag, ".status_regs"}, 128'(status_regs), 128'(exp_sr));
      chk({tag, ".fail_valid"}, 128'(fail_valid), 128'(m_fv));
      chk({tag, ".fail_idx"}, 128'(fail_idx), 128'(6'(m_fi)));
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_reg[i]  = '0;
         m_lock[i] = 1'b0;
      end
      m_fv = 1'b0;
      m_fi = 0;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clock);
      reset     = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clock);
         #1;
         chk("reset.req_ready", 128'(req_ready), 128'(1'b0));
      end
      model_clear();
      chk("reset.rsp_valid", 128'(rsp_valid), 128'(1'b0));
      chk("reset.rsp_data", 128'(rsp_data), 128'(32'h0));
      chk("reset.rsp_error", 128'(rsp_error), 128'(1'b0));
      check_state("reset");
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("post_reset.req_ready", 128'(req_ready), 128'(1'b1));
   endtask

   // One full request/response; the model decides the expected response.
   task automatic xfer(input bit wr, input logic [11:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input int hold);
      int          idx;
      bit          ok;
      logic [31:0] exp_data;
      bit          exp_err;
      logic [31:0] bm;
      int          n;
      idx      = int'(addr) / 4;
      ok       = (int'(addr) % 4 == 0) && (idx < N);
      exp_data = '0;
      exp_err  = 1'b0;
      if (!ok) exp_err = 1'b1;
      else if (!wr) exp_data = m_reg[idx];
      else if (m_lock[idx]) exp_err = 1'b1;
      else begin
         bm = '0;
         for (int b = 0; b < 4; b++) if (mask[b]) bm = bm | (32'hFF << (8 * b));
         m_reg[idx] = (m_reg[idx] & ~bm) | (data & bm);
         if (m_reg[idx][15:0] != 16'h0) m_lock[idx] = 1'b1;
         if (m_reg[idx][15:0] == 16'h3333 && !m_fv) begin
            m_fv = 1'b1;
            m_fi = idx;
         end
      end

      @(negedge clock);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_data  = data;
      req_mask  = mask;
      rsp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < 10) begin
         @(negedge clock);
         n++;
      end
      chk("xfer.req_ready", 128'(req_ready), 128'(1'b1));
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      chk("xfer.rsp_valid", 128'(rsp_valid), 128'(1'b1));
      chk("xfer.rsp_data", 128'(rsp_data), 128'(exp_data));
      chk("xfer.rsp_error", 128'(rsp_error), 128'(exp_err));
      chk("xfer.busy_ready", 128'(req_ready), 128'(1'b0));
      check_state("xfer");
      for (int k = 0; k < hold; k++) begin
         @(posedge clock);
         #1;
         chk("hold.rsp_valid", 128'(rsp_valid), 128'(1'b1));
         chk("hold.rsp_data", 128'(rsp_data), 128'(exp_data));
         chk("hold.rsp_error", 128'(rsp_error), 128'(exp_err));
         chk("hold.req_ready", 128'(req_ready), 128'(1'b0));
      end
      @(negedge clock);
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      chk("done.rsp_valid", 128'(rsp_valid), 128'(1'b0));
      chk("done.req_ready", 128'(req_ready), 128'(1'b1));
   endtask

   initial begin
      logic [11:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      bit          wr;

      reset     = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      req_mask  = '0;
      rsp_ready = 1'b0;
      model_clear();

      // Reset then read
      do_reset(2);
      xfer(1'b0, 12'h000, 32'h0, 4'h0, 0);

      // Pass then lock
      xfer(1'b1, 12'h004, 32'h0000_5555, 4'hF, 0);
      chk("pass.reg1", 128'(status_regs[1]), 128'(32'h0000_5555));
      xfer(1'b1, 12'h004, 32'h0007_3333, 4'hF, 1);
      chk("locked.reg1", 128'(status_regs[1]), 128'(32'h0000_5555));
      chk("locked.fail_valid", 128'(fail_valid), 128'(1'b0));

      // First-fail capture
      xfer(1'b1, 12'h008, 32'h0042_3333, 4'hF, 0);
      xfer(1'b1, 12'h000, 32'h0001_3333, 4'hF, 0);
      chk("ff.fail_valid", 128'(fail_valid), 128'(1'b1));
      chk("ff.fail_idx", 128'(fail_idx), 128'(6'd2));
      xfer(1'b0, 12'h008, 32'h0, 4'h0, 0);
      chk("ff.read8", 128'(rsp_data), 128'(32'h0042_3333));

      // Byte mask
      do_reset(1);
      xfer(1'b1, 12'h000, 32'hAAAA_0000, 4'hC, 0);
      xfer(1'b1, 12'h000, 32'h0000_5555, 4'h3, 0);
      chk("mask.reg0", 128'(status_regs[0]), 128'(32'hAAAA_5555));
      xfer(1'b1, 12'h000, 32'h0000_0000, 4'hF, 0);

      // Errors
      xfer(1'b1, 12'h002, 32'h1234_5678, 4'hF, 0);
      xfer(1'b0, 12'h010, 32'h0, 4'h0, 0);

      // Backpressure with a mid-response reset
      xfer(1'b1, 12'h004, 32'h9876_0001, 4'hF, 0);
      @(negedge clock);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 12'h004;
      rsp_ready = 1'b0;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      chk("bp.rsp_data", 128'(rsp_data), 128'(m_reg[1]));
      for (int k = 0; k < 2; k++) begin
         @(posedge clock);
         #1;
         chk("bp.rsp_valid", 128'(rsp_valid), 128'(1'b1));
         chk("bp.rsp_data_hold", 128'(rsp_data), 128'(m_reg[1]));
         chk("bp.req_ready", 128'(req_ready), 128'(1'b0));
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      model_clear();
      chk("bp_rst.rsp_valid", 128'(rsp_valid), 128'(1'b0));
      chk("bp_rst.rsp_data", 128'(rsp_data), 128'(32'h0));
      chk("bp_rst.req_ready", 128'(req_ready), 128'(1'b0));
      check_state("bp_rst");
      @(negedge clock);
      reset = 1'b0;

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         if (t % 15 == 14) do_reset(1);
         if ($urandom_range(0, 9) == 0) addr = 12'($urandom_range(0, 23));
         else addr = 12'(4 * $urandom_range(0, N - 1));
         data = $urandom;
         if ($urandom_range(0, 2) == 0) data[15:0] = 16'h3333;
         if ($urandom_range(0, 3) == 0) data[15:0] = 16'h0000;
         mask = 4'($urandom);
         wr   = 1'($urandom_range(0, 1));
         xfer(wr, addr, data, mask, int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/test_indicator_regs.md
# test_indicator_regs

Memory-mapped bank of per-test status registers that test software writes to report pass/fail. It sits directly upstream of the simulation test-finisher: it accepts single-beat register requests from the core-subsystem peripheral bus and drives the `status_regs` array the finisher samples. Registers are write-locked once a test posts a final code, so a later stray write cannot turn a reported result into a false pass.

## Interface
Parameters:
- `NCONCURRENT`, 1: number of status registers (tests); 1..64.
- `CODEBITS`, 16: width of status field `[CODEBITS-1:0]`; error code occupies `[2*CODEBITS-1:CODEBITS]`.
- `REGBYTES`, 4: bytes per register; `8*REGBYTES >= 2*CODEBITS`.
- `ADDRBITS`, 12: request address width (byte address).

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDRBITS  byte address.
- `req_data`  in  8*REGBYTES  write data.
- `req_mask`  in  REGBYTES  byte enables for writes.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_data`  out  8*REGBYTES  read data; 0 for writes and errors.
- `rsp_error`  out  1  request rejected (bad address or locked write).
- `status_regs`  out  [NCONCURRENT] x 8*REGBYTES  register contents, to the finisher.
- `fail_valid`  out  1  at least one register locked with FAILCODE.
- `fail_idx`  out  6  index of the first register to lock with FAILCODE.

## Operation
- Register `i` is at byte address `i*REGBYTES`. A request is an error if the address is unaligned (`req_addr % REGBYTES != 0`) or `i >= NCONCURRENT`. An error request changes no state.
- FSM with two states:
  - IDLE: `req_ready = 1`. On accept, perform the access and go to RESP.
  - RESP: `req_ready = 0`, `rsp_valid = 1`. On `rsp_ready`, go to IDLE.
- Write to an unlocked register: for each byte `b` with `req_mask[b]=1`, the byte takes `req_data`; other bytes are kept.
  - If the resulting status field is nonzero, set `lock[i]`.
  - If the status field equals FAILCODE (`16'h3333` at `CODEBITS=16`) and `fail_valid=0`, set `fail_valid=1` and `fail_idx=i`.
  - The response has `rsp_error=0`.
- Write to a locked register: ignored; the response has `rsp_error=1`.
- An all-zero mask write is legal and changes nothing. It does not lock a register whose status is already 0.
- Read: `rsp_data` is the register value captured at accept time; `rsp_error=0`.
- The response payload (`rsp_data`, `rsp_error`) is registered at accept and held stable while `rsp_valid=1 && !rsp_ready`.
- Locks, `fail_valid` and `fail_idx` are cleared only by `reset`.

## Timing
- Reset (sampled on a `clock` edge) forces, at that edge:
  - FSM to IDLE, all `status_regs` to 0, all locks to 0;
  - `rsp_valid=0`, `rsp_data=0`, `rsp_error=0`, `fail_valid=0`, `fail_idx=0`.
- While `reset=1`, `req_ready=0`.
- Reset while in RESP discards the pending response; no handshake completes in the reset cycle.
- Accept at edge N:
  - `status_regs`, `lock`, `fail_*` update at edge N, so they are visible after N;
  - `rsp_valid=1` from edge N.
- If `rsp_ready=1` in the cycle after N, the FSM is back in IDLE at edge N+1 and `req_ready=1` after N+1. Peak throughput is therefore one request per 2 cycles.
- `req_ready` depends only on state and `reset`, never on `req_valid`.
- `rsp_valid` depends only on state; no combinational path from `req_*` to `rsp_*`.
- `status_regs` outputs come directly from flops.

## Test plan
- Reset then read: `reset` for 2 cycles, then read addr 0 → `rsp_data=0`, `rsp_error=0`; all `status_regs` 0; `req_ready` 0 during reset and 1 after.
- Pass then lock (NCONCURRENT=2): write `0x0000_5555` mask `4'hF` to addr 4 → `status_regs[1]=0x5555`, no error. Then write `0x0007_3333` to addr 4 → `rsp_error=1`, register still `0x5555`, `fail_valid=0`.
- First-fail capture (NCONCURRENT=4): write `0x0042_3333` to addr 8, then `0x0001_3333` to addr 0 → `fail_valid=1`, `fail_idx=2`. Read addr 8 → `0x0042_3333`.
- Byte mask: write `0xAAAA_0000` mask `4'hC` to addr 0, then `0x0000_5555` mask `4'h3` → final value `0xAAAA_5555`. The first write does not lock; the second does.
- Errors (NCONCURRENT=2): write to addr 2 → `rsp_error=1`; read addr 8 → `rsp_error=1`, `rsp_data=0`; no register changes.
- Backpressure and reset: hold `rsp_ready=0` for 5 cycles after a read → `rsp_valid` and `rsp_data` stable and `req_ready=0` throughout. Assert `reset` in cycle 3 → `rsp_valid=0` the next cycle, registers cleared.
